// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sequencer: state encoding, datapath
// register-A mux codes and the default iteration count.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_ITER = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic [1:0] MUX_INIT_ANGLE = 2'b00;
  localparam logic [1:0] MUX_FEEDBACK   = 2'b01;
  localparam logic [1:0] MUX_INIT_VEC   = 2'b10;
  localparam logic [1:0] MUX_HOLD       = 2'b11;

  localparam int DEFAULT_NUM_ITER = 8;

  // Rotation loads the initial angle; vectoring loads the initial vector.
  function automatic logic [1:0] load_mux(input logic mode);
    return mode ? MUX_INIT_VEC : MUX_INIT_ANGLE;
  endfunction

endpackage

// File: rtl/cordic_ctrl.sv
// CORDIC operation sequencer (IDLE -> LOAD -> ITER x NUM_ITER -> DONE), falling-edge clocked.
// Define CORDIC_CTRL_CHECK_EN to cross-check the datapath shift index against iter_cnt.
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int NUM_ITER = DEFAULT_NUM_ITER
) (
  input  logic       clka,
  input  logic       reset,
  input  logic       start,
  input  logic       mode_in,
  input  logic [3:0] counter,
  output logic       cordic_mode,
  output logic [1:0] in_mux_ctl,
  output logic       counter_rst,
  output logic       counter_hold,
  output logic       busy,
  output logic       done,
  output logic       out_valid,
  output logic       err
);

  if ((NUM_ITER < 1) || (NUM_ITER > 8)) begin : g_bad_num_iter
    $error("cordic_ctrl: NUM_ITER must be within 1..8");
  end

  localparam logic [3:0] LAST_ITER = 4'(NUM_ITER - 1);

  state_e     state_r;
  logic [3:0] iter_cnt_r;
  logic       arm_r;
  logic       mode_r;
  logic [1:0] mux_r;
  logic       cnt_rst_r;
  logic       cnt_hold_r;
  logic       busy_r;
  logic       done_r;
  logic       valid_r;

`ifdef CORDIC_CTRL_CHECK_EN
  logic       err_r;
`endif

  // Sequencer state, iteration counter and all registered datapath controls.
  always_ff @(negedge clka or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      iter_cnt_r <= 4'd0;
      arm_r      <= 1'b0;
      mode_r     <= 1'b0;
      mux_r      <= MUX_HOLD;
      cnt_rst_r  <= 1'b0;
      cnt_hold_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      valid_r    <= 1'b0;
`ifdef CORDIC_CTRL_CHECK_EN
      err_r      <= 1'b0;
`endif
    end else begin
      // The first edge after reset release only arms the start input.
      arm_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (start && arm_r) begin
            state_r    <= ST_LOAD;
            mode_r     <= mode_in;
            valid_r    <= 1'b0;
            mux_r      <= load_mux(mode_in);
            cnt_rst_r  <= 1'b1;
            cnt_hold_r <= 1'b1;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
          end else begin
            state_r    <= ST_IDLE;
            mux_r      <= MUX_HOLD;
            cnt_rst_r  <= 1'b0;
            cnt_hold_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
          end
        end
        ST_LOAD: begin
          state_r    <= ST_ITER;
          iter_cnt_r <= 4'd0;
          mux_r      <= MUX_FEEDBACK;
          cnt_rst_r  <= 1'b0;
          cnt_hold_r <= 1'b0;
          busy_r     <= 1'b1;
          done_r     <= 1'b0;
        end
        ST_ITER: begin
`ifdef CORDIC_CTRL_CHECK_EN
          if (counter != iter_cnt_r) begin
            err_r <= 1'b1;
          end else begin
            err_r <= err_r;
          end
`endif
          if (iter_cnt_r == LAST_ITER) begin
            state_r    <= ST_DONE;
            iter_cnt_r <= 4'd0;
            mux_r      <= MUX_HOLD;
            cnt_hold_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            valid_r    <= 1'b1;
          end else begin
            state_r    <= ST_ITER;
            iter_cnt_r <= iter_cnt_r + 4'd1;
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          mux_r      <= MUX_HOLD;
          cnt_rst_r  <= 1'b0;
          cnt_hold_r <= 1'b1;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          iter_cnt_r <= 4'd0;
          mux_r      <= MUX_HOLD;
          cnt_rst_r  <= 1'b0;
          cnt_hold_r <= 1'b1;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign cordic_mode  = mode_r;
  assign in_mux_ctl   = mux_r;
  assign counter_rst  = cnt_rst_r;
  assign counter_hold = cnt_hold_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign out_valid    = valid_r;

`ifdef CORDIC_CTRL_CHECK_EN
  assign err = err_r;
`else
  logic unused_counter_s;
  assign unused_counter_s = ^counter;
  assign err = 1'b0;
`endif

endmodule
